// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and defaults for the bus arbiter slice
package cpu_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - two-input data multiplexer
module mux_2to1 #(
    parameter int W = 8
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         sel,
    output logic [W-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester round-robin bus arbiter with hold timeout and lockout
module bus_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        done,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    output logic [1:0]        grant,
    output logic              sel,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_valid,
    output logic              timeout
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    arb_state_t        state;
    logic [7:0]        hold_cnt;
    logic [1:0]        lock;
    logic              last_owner;
    logic [1:0]        elig;
    logic              owner;
    logic              idle_win;
    logic              at_max;
    logic              release_now;
    logic              forced;
    logic              other_ok;
    logic [DATA_W-1:0] mux_out;

    always_comb begin
        elig        = req & ~lock;
        owner       = (state == OWN1);
        idle_win    = (elig == 2'b11) ? ~last_owner : elig[1];
        at_max      = (hold_cnt == HOLD_LIMIT);
        release_now = done[owner] | ~req[owner] | at_max;
        // done arriving on the limit cycle wins: that is a clean release
        forced      = at_max & ~done[owner];
        other_ok    = elig[~owner];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 2'b00;
            sel        <= 1'b0;
            hold_cnt   <= 8'd0;
            lock       <= 2'b00;
            last_owner <= 1'b1;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            lock    <= lock & req;
            case (state)
                IDLE: begin
                    if (|elig) begin
                        state      <= idle_win ? OWN1 : OWN0;
                        grant      <= idle_win ? 2'b10 : 2'b01;
                        sel        <= idle_win;
                        last_owner <= idle_win;
                        hold_cnt   <= 8'd1;
                    end
                end
                OWN0, OWN1: begin
                    if (release_now) begin
                        if (forced) begin
                            timeout     <= 1'b1;
                            lock[owner] <= 1'b1;
                        end
                        if (other_ok) begin
                            state      <= owner ? OWN0 : OWN1;
                            grant      <= owner ? 2'b01 : 2'b10;
                            sel        <= ~owner;
                            last_owner <= ~owner;
                            hold_cnt   <= 8'd1;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    mux_2to1 #(
        .W(DATA_W)
    ) u_mux (
        .in0(data_in0),
        .in1(data_in1),
        .sel(sel),
        .out(mux_out)
    );

    assign bus_valid = |grant;
    assign bus_out   = bus_valid ? mux_out : '0;

endmodule
